// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage branch hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NB_CNT   = 2;
  // Cycles until a result reaches the ID comparator: EX/MEM forward vs. register file at WB.
  localparam int unsigned CNT_ALU  = 1;
  localparam int unsigned CNT_LOAD = 2;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pending_counter.sv
// Countdown for one architectural register; pending while nonzero.
module pending_counter #(
  parameter int unsigned NB_CNT = hazard_pkg::NB_CNT
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic [NB_CNT-1:0] load_val_i,
  output logic              pending_o
);

  logic [NB_CNT-1:0] cnt_d, cnt_q;

  // A same-cycle load overrides the decrement: the newer writer wins.
  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// Per-register pending-write scoreboard; stalls ID branches whose operands are not yet forwardable.
module branch_hazard_scoreboard #(
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_CNT  = hazard_pkg::NB_CNT,
  parameter int unsigned NB_STAT = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               enable_i,
  input  logic               ID_valid_i,
  input  logic               ID_is_branch_i,
  input  logic [NB_REG-1:0]  ID_rs_i,
  input  logic [NB_REG-1:0]  ID_rt_i,
  input  logic               ID_reg_write_i,
  input  logic [NB_REG-1:0]  ID_write_reg_i,
  input  logic               ID_mem_to_reg_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [NB_STAT-1:0] stall_count_o
);
  import hazard_pkg::*;

  logic [N_REGS-1:0]  pend;
  logic               issue;
  logic               wr_en;
  logic [NB_CNT-1:0]  load_val;
  logic               rs_pend, rt_pend;
  logic [NB_STAT-1:0] stat_d, stat_q;

  assign issue    = enable_i & ID_valid_i & ~stall_o & ~flush_i;
  assign wr_en    = issue & ID_reg_write_i & (ID_write_reg_i != NB_REG'(REG_ZERO));
  assign load_val = ID_mem_to_reg_i ? NB_CNT'(CNT_LOAD) : NB_CNT'(CNT_ALU);

  // r0 is hard-wired, so it never has a writer in flight.
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < N_REGS; r++) begin : g_reg
    pending_counter #(
      .NB_CNT (NB_CNT)
    ) u_cnt (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .enable_i   (enable_i),
      .load_i     (wr_en && (ID_write_reg_i == NB_REG'(r))),
      .load_val_i (load_val),
      .pending_o  (pend[r])
    );
  end

  assign rs_pend = pend[ID_rs_i];
  assign rt_pend = pend[ID_rt_i];

  assign stall_o = ID_valid_i & ID_is_branch_i & ~flush_i & (rs_pend | rt_pend);

  always_comb begin
    stat_d = stat_q;
    if (enable_i && stall_o && (stat_q != '1)) begin
      stat_d = stat_q + NB_STAT'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stall_count_o = stat_q;

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Randomized and directed bench for branch_hazard_scoreboard against a cycle-level reference model.
module tb_branch_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, v, br, rw, mem, fl;
  logic [4:0]  rs, rt, wr;
  logic        stall, stall8;
  logic [15:0] cnt16;
  logic [7:0]  cnt8;

  int unsigned cnt_m [32];
  int unsigned stat16_m, stat8_m;
  int unsigned seen16, seen8;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_hazard_scoreboard u_dut (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .enable_i        (en),
    .ID_valid_i      (v),
    .ID_is_branch_i  (br),
    .ID_rs_i         (rs),
    .ID_rt_i         (rt),
    .ID_reg_write_i  (rw),
    .ID_write_reg_i  (wr),
    .ID_mem_to_reg_i (mem),
    .flush_i         (fl),
    .stall_o         (stall),
    .stall_count_o   (cnt16)
  );

  // Narrow statistic so saturation is reachable in a short run.
  branch_hazard_scoreboard #(
    .NB_STAT (8)
  ) u_dut8 (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .enable_i        (en),
    .ID_valid_i      (v),
    .ID_is_branch_i  (br),
    .ID_rs_i         (rs),
    .ID_rt_i         (rt),
    .ID_reg_write_i  (rw),
    .ID_write_reg_i  (wr),
    .ID_mem_to_reg_i (mem),
    .flush_i         (fl),
    .stall_o         (stall8),
    .stall_count_o   (cnt8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    stat16_m = 0;
    stat8_m  = 0;
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cyc(input bit iv, input bit ibr, input logic [4:0] irs, input logic [4:0] irt,
                     input bit irw, input logic [4:0] iwr, input bit imem, input bit ifl,
                     input bit ien, output bit st);
    bit exp_st;
    bit iss;
    @(negedge clk);
    v = iv; br = ibr; rs = irs; rt = irt; rw = irw; wr = iwr; mem = imem; fl = ifl; en = ien;
    #1;
    exp_st = iv && ibr && !ifl &&
             ((irs != 0 && cnt_m[irs] != 0) || (irt != 0 && cnt_m[irt] != 0));
    chk("stall", stall, exp_st);
    chk("stall_w8", stall8, exp_st);
    chk("stall_count", cnt16, stat16_m);
    chk("stall_count_w8", cnt8, stat8_m);
    seen16 = cnt16;
    seen8  = cnt8;
    st = exp_st;
    @(posedge clk);
    if (ien) begin
      iss = iv && !exp_st && !ifl;
      for (int r = 1; r < 32; r++) begin
        if (iss && irw && iwr == r) cnt_m[r] = imem ? 2 : 1;
        else if (cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
      end
      if (exp_st) begin
        if (stat16_m < 65535) stat16_m++;
        if (stat8_m < 255) stat8_m++;
      end
    end
  endtask

  task automatic nop();
    bit st;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, st);
  endtask

  task automatic alu(input logic [4:0] rd);
    bit st;
    cyc(1, 0, 0, 0, 1, rd, 0, 0, 1, st);
  endtask

  task automatic lw(input logic [4:0] rd);
    bit st;
    cyc(1, 0, 0, 0, 1, rd, 1, 0, 1, st);
  endtask

  // Hold a branch in ID until it issues; returns the number of stalled cycles (bounded).
  task automatic br_until(input logic [4:0] irs, input logic [4:0] irt, output int n);
    bit st;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, irs, irt, 0, 0, 0, 0, 1, st);
      if (!st) break;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v = 0; br = 0; rs = 0; rt = 0; rw = 0; wr = 0; mem = 0; fl = 0; en = 1;
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_count", cnt16, 0);
    model_clear();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit st;
    v = 0; br = 0; rs = 0; rt = 0; rw = 0; wr = 0; mem = 0; fl = 0; en = 1;
    model_clear();

    do_reset();
    alu(3);
    br_until(3, 0, n);
    chk("add_beq_stalls", n, 1);
    nop();
    chk("add_beq_count", seen16, 1);

    do_reset();
    lw(5);
    br_until(5, 6, n);
    chk("lw_bne_stalls", n, 2);
    nop();
    chk("lw_bne_count", seen16, 2);

    do_reset();
    lw(5);
    alu(7);
    br_until(5, 7, n);
    chk("lw_add_beq_stalls", n, 1);
    nop();
    chk("lw_add_beq_count", seen16, 1);

    do_reset();
    alu(0);
    br_until(0, 0, n);
    chk("r0_stalls", n, 0);
    nop();
    chk("r0_count", seen16, 0);

    do_reset();
    lw(4);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, st);
      if (st) n++;
    end
    chk("disabled_stalls", n, 5);
    chk("disabled_count_held", seen16, 0);
    br_until(4, 0, n);
    chk("reenable_stalls", n, 2);
    nop();
    chk("reenable_count", seen16, 2);

    // Reset while a branch is stalled drops stall_o without any clock edge.
    do_reset();
    lw(9);
    cyc(1, 1, 0, 9, 0, 0, 0, 0, 1, st);
    chk("pre_reset_stall", st, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midstall_reset_stall", stall, 1'b0);
    chk("midstall_reset_count", cnt16, 0);
    chk("midstall_reset_count_w8", cnt8, 0);
    v = 0; br = 0;
    model_clear();
    #2;
    rst_n = 1'b1;

    // Enough load-use stalls to saturate the narrow statistic.
    for (int i = 0; i < 300; i++) begin
      lw(4);
      br_until(4, 0, n);
    end
    nop();
    chk("sat_count_w8", seen8, 8'hFF);
    chk("sat_count_w16", seen16, 600);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(9, 0) != 0, $urandom_range(1, 0) != 0,
          5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
          $urandom_range(9, 0) < 7, 5'($urandom_range(7, 0)),
          $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0,
          $urandom_range(19, 0) != 0, st);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
